// File: rtl/lcd_host_seq.sv
// lcd_host_seq: host-side partner of the LCD controller. Serves the source image as IROM,
// replays a stored command script over cmd/busy/done, and captures the IRAM write-back.
module lcd_host_seq #(
   parameter int unsigned SCR_DEPTH = 16,
   parameter int unsigned SCR_AW    = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              img_we,
   input  logic [5:0]        img_addr,
   input  logic [7:0]        img_data,
   input  logic              scr_we,
   input  logic [SCR_AW-1:0] scr_addr,
   input  logic [3:0]        scr_data,
   output logic [3:0]        cmd,
   output logic              cmd_valid,
   input  logic              busy,
   input  logic              done,
   input  logic              IROM_rd,
   input  logic [5:0]        IROM_A,
   output logic [7:0]        IROM_Q,
   input  logic              IRAM_valid,
   input  logic [5:0]        IRAM_A,
   input  logic [7:0]        IRAM_D,
   input  logic [5:0]        res_addr,
   output logic [7:0]        res_data,
   output logic [15:0]       checksum,
   output logic [6:0]        wr_count,
   output logic              finished,
   output logic              error
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_RDY  = 3'd1;
   localparam logic [2:0] S_ISSUE     = 3'd2;
   localparam logic [2:0] S_WAIT_DONE = 3'd3;
   localparam logic [2:0] S_FINISH    = 3'd4;
   localparam logic [2:0] S_ERR       = 3'd5;

   localparam logic [SCR_AW:0] PTR_END   = (SCR_AW + 1)'(SCR_DEPTH);
   localparam logic [TW-1:0]   TMR_LAST  = TW'(TIMEOUT - 1);
   localparam logic [6:0]      WR_MAX    = 7'd64;
   localparam logic [3:0]      CMD_NOP   = 4'hF;
   localparam logic [3:0]      CMD_WRITE = 4'h0;

   logic [7:0] img_mem [0:63];
   logic [3:0] scr_mem [0:SCR_DEPTH-1];
   logic [7:0] res_mem [0:63];

   logic [2:0]      state_q,     state_d;
   logic [3:0]      cmd_q,       cmd_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic [SCR_AW:0] ptr_q,       ptr_d;
   logic [TW-1:0]   timer_q,     timer_d;
   logic [15:0]     checksum_q,  checksum_d;
   logic [6:0]      wr_count_q,  wr_count_d;
   logic            finished_q,  finished_d;
   logic            error_q,     error_d;

   logic            capture;

   assign capture = (state_q == S_WAIT_DONE) && IRAM_valid;

   // Memories carry no reset so image, script and results survive a run abort.
   always_ff @(posedge clk) begin
      if (img_we) begin
         img_mem[img_addr] <= img_data;
      end
      if (scr_we) begin
         scr_mem[scr_addr] <= scr_data;
      end
      if (capture) begin
         res_mem[IRAM_A] <= IRAM_D;
      end
   end

   assign IROM_Q   = IROM_rd ? img_mem[IROM_A] : '0;
   assign res_data = res_mem[res_addr];

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;
      ptr_d       = ptr_q;
      timer_d     = timer_q;
      checksum_d  = checksum_q;
      wr_count_d  = wr_count_q;
      finished_d  = finished_q;
      error_d     = error_q;

      if (capture) begin
         checksum_d = checksum_q + 16'(IRAM_D);
         if (wr_count_q != WR_MAX) begin
            wr_count_d = wr_count_q + 7'd1;
         end
      end

      case (state_q)
         S_IDLE, S_FINISH, S_ERR: begin
            if (start) begin
               state_d    = S_WAIT_RDY;
               ptr_d      = '0;
               timer_d    = '0;
               checksum_d = '0;
               wr_count_d = '0;
               finished_d = 1'b0;
               error_d    = 1'b0;
            end
         end
         S_WAIT_RDY: begin
            if (!busy) begin
               // Past the last entry the script is closed with an implicit write.
               cmd_d       = (ptr_q == PTR_END) ? CMD_WRITE : scr_mem[ptr_q[SCR_AW-1:0]];
               cmd_valid_d = 1'b1;
               ptr_d       = ptr_q + 1'b1;
               timer_d     = '0;
               state_d     = S_ISSUE;
            end else begin
               timer_d = timer_q + 1'b1;
               if (timer_q == TMR_LAST) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            cmd_valid_d = 1'b0;
            cmd_d       = CMD_NOP;
            state_d     = (cmd_q == CMD_WRITE) ? S_WAIT_DONE : S_WAIT_RDY;
         end
         S_WAIT_DONE: begin
            timer_d = timer_q + 1'b1;
            if (done) begin
               state_d    = S_FINISH;
               finished_d = 1'b1;
            end else if (timer_q == TMR_LAST) begin
               state_d = S_ERR;
               error_d = 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            cmd_d       = CMD_NOP;
            cmd_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cmd_q       <= CMD_NOP;
         cmd_valid_q <= 1'b0;
         ptr_q       <= '0;
         timer_q     <= '0;
         checksum_q  <= '0;
         wr_count_q  <= '0;
         finished_q  <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         ptr_q       <= ptr_d;
         timer_q     <= timer_d;
         checksum_q  <= checksum_d;
         wr_count_q  <= wr_count_d;
         finished_q  <= finished_d;
         error_q     <= error_d;
      end
   end

   assign cmd       = cmd_q;
   assign cmd_valid = cmd_valid_q;
   assign checksum  = checksum_q;
   assign wr_count  = wr_count_q;
   assign finished  = finished_q;
   assign error     = error_q;

endmodule

// File: tb/tb_lcd_host_seq.sv
// tb_lcd_host_seq: drives lcd_host_seq with a behavioural LCD controller and checks
// commands, IROM reads, IRAM capture and status through queue-based scoreboards.
module tb_lcd_host_seq;

   localparam int unsigned SCR_DEPTH = 16;
   localparam int unsigned SCR_AW    = 4;
   localparam int unsigned TIMEOUT   = 255;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              img_we = 1'b0;
   logic [5:0]        img_addr = '0;
   logic [7:0]        img_data = '0;
   logic              scr_we = 1'b0;
   logic [SCR_AW-1:0] scr_addr = '0;
   logic [3:0]        scr_data = '0;
   logic [3:0]        cmd;
   logic              cmd_valid;
   logic              busy = 1'b1;
   logic              done = 1'b0;
   logic              IROM_rd = 1'b0;
   logic [5:0]        IROM_A = '0;
   logic [7:0]        IROM_Q;
   logic              IRAM_valid = 1'b0;
   logic [5:0]        IRAM_A = '0;
   logic [7:0]        IRAM_D = '0;
   logic [5:0]        res_addr = '0;
   logic [7:0]        res_data;
   logic [15:0]       checksum;
   logic [6:0]        wr_count;
   logic              finished;
   logic              error;

   lcd_host_seq #(
      .SCR_DEPTH (SCR_DEPTH),
      .SCR_AW    (SCR_AW),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .img_we     (img_we),
      .img_addr   (img_addr),
      .img_data   (img_data),
      .scr_we     (scr_we),
      .scr_addr   (scr_addr),
      .scr_data   (scr_data),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .busy       (busy),
      .done       (done),
      .IROM_rd    (IROM_rd),
      .IROM_A     (IROM_A),
      .IROM_Q     (IROM_Q),
      .IRAM_valid (IRAM_valid),
      .IRAM_A     (IRAM_A),
      .IRAM_D     (IRAM_D),
      .res_addr   (res_addr),
      .res_data   (res_data),
      .checksum   (checksum),
      .wr_count   (wr_count),
      .finished   (finished),
      .error      (error)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_cmd_q [$];
   int          exp_dat_q [$];
   logic [7:0]  img_model [64];
   logic [7:0]  ctrl_buf  [64];
   int          opx, opy;
   int          pulse_cnt = 0;
   logic        prev_valid = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Command monitor: pulse width, idle code and issued codes against the scoreboard.
   always @(negedge clk) begin
      if (cmd_valid === 1'b1) begin
         pulse_cnt++;
         check_val("cmd_pulse_width", {31'd0, prev_valid}, 32'd0);
         check_val("cmd_sb_avail", {31'd0, exp_cmd_q.size() != 0}, 32'd1);
         if (exp_cmd_q.size() != 0) begin
            check_val("cmd_code", {28'd0, cmd}, exp_cmd_q.pop_front());
         end
      end else begin
         check_val("cmd_idle_F", {28'd0, cmd}, 32'hF);
      end
      prev_valid = cmd_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic load_image;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         img_we   = 1'b1;
         img_addr = 6'(i);
         img_data = 8'(i);
         img_model[i] = 8'(i);
      end
      @(negedge clk);
      img_we = 1'b0;
   endtask

   task automatic write_script(input int addr, input int code);
      @(negedge clk);
      scr_we   = 1'b1;
      scr_addr = SCR_AW'(addr);
      scr_data = 4'(code);
      @(negedge clk);
      scr_we = 1'b0;
   endtask

   task automatic pulse_start;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Behavioural controller: fetch image, execute commands, write back on code 0.
   // abort_after >= 0 stops the write-back after that many writes.
   task automatic ctrl_run(input int abort_after);
      int w;
      int code;
      int a0, m;
      busy = 1'b1;
      opx  = 4;
      opy  = 4;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         IROM_rd = 1'b1;
         IROM_A  = 6'(i);
         exp_dat_q.push_back(int'(img_model[i]));
         #1;
         ctrl_buf[i] = IROM_Q;
         check_val("irom_q", {24'd0, IROM_Q}, exp_dat_q.pop_front());
      end
      @(negedge clk);
      IROM_rd = 1'b0;
      #1;
      check_val("irom_rd_low", {24'd0, IROM_Q}, 32'd0);
      busy = 1'b0;
      for (int k = 0; k < 24; k++) begin
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (cmd_valid !== 1'b1 && w < 20);
         if (cmd_valid !== 1'b1) begin
            check_val("cmd_wait", {31'd0, cmd_valid}, 32'd1);
            return;
         end
         code = int'(cmd);
         busy = 1'b1;
         if (code == 0) begin
            for (int i = 0; i < 64; i++) begin
               @(negedge clk);
               if (i == abort_after) begin
                  IRAM_valid = 1'b0;
                  return;
               end
               IRAM_valid = 1'b1;
               IRAM_A     = 6'(i);
               IRAM_D     = ctrl_buf[i];
            end
            @(negedge clk);
            IRAM_valid = 1'b0;
            done       = 1'b1;
            @(negedge clk);
            done = 1'b0;
            busy = 1'b0;
            return;
         end
         case (code)
            1: if (opy > 1) opy--;
            2: if (opy < 7) opy++;
            3: if (opx > 1) opx--;
            4: if (opx < 7) opx++;
            5: begin
               a0 = (opy - 1) * 8 + (opx - 1);
               m  = int'(ctrl_buf[a0]);
               if (int'(ctrl_buf[a0 + 1]) > m) m = int'(ctrl_buf[a0 + 1]);
               if (int'(ctrl_buf[a0 + 8]) > m) m = int'(ctrl_buf[a0 + 8]);
               if (int'(ctrl_buf[a0 + 9]) > m) m = int'(ctrl_buf[a0 + 9]);
               ctrl_buf[a0]     = 8'(m);
               ctrl_buf[a0 + 1] = 8'(m);
               ctrl_buf[a0 + 8] = 8'(m);
               ctrl_buf[a0 + 9] = 8'(m);
            end
            default: ;
         endcase
         @(negedge clk);
         busy = 1'b0;
      end
   endtask

   task automatic check_status(input string tag, input int ck, input int wc, input int fin, input int err);
      @(negedge clk);
      check_val({tag, "_checksum"}, {16'd0, checksum}, 32'(ck));
      check_val({tag, "_wr_count"}, {25'd0, wr_count}, 32'(wc));
      check_val({tag, "_finished"}, {31'd0, finished}, 32'(fin));
      check_val({tag, "_error"},    {31'd0, error},    32'(err));
   endtask

   // Expected write-back: identity image, with the MAX window at (4,4) forced to 36.
   task automatic check_results(input bit max_applied);
      int e;
      for (int i = 0; i < 64; i++) begin
         e = i;
         if (max_applied && (i == 27 || i == 28 || i == 35 || i == 36)) e = 36;
         @(negedge clk);
         res_addr = 6'(i);
         exp_dat_q.push_back(e);
         #1;
         check_val("res_data", {24'd0, res_data}, exp_dat_q.pop_front());
      end
   endtask

   initial begin
      int n;
      int p0;
      repeat (3) @(negedge clk);
      check_status("reset", 0, 0, 0, 0);
      check_val("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      reset = 1'b0;
      busy  = 1'b0;

      load_image();

      // Run 1: single write command.
      write_script(0, 0);
      exp_cmd_q.push_back(0);
      pulse_start();
      ctrl_run(-1);
      check_status("run1", 16'h07E0, 64, 1, 0);
      @(negedge clk);
      IRAM_valid = 1'b1;
      IRAM_A     = 6'd0;
      IRAM_D     = 8'hAA;
      @(negedge clk);
      IRAM_valid = 1'b0;
      check_status("run1_stray", 16'h07E0, 64, 1, 0);
      check_results(1'b0);

      // Run 2: MAX at the default window, then write.
      write_script(0, 5);
      write_script(1, 0);
      exp_cmd_q.push_back(5);
      exp_cmd_q.push_back(0);
      pulse_start();
      ctrl_run(-1);
      check_status("run2", 2034, 64, 1, 0);
      check_results(1'b1);

      // Run 3: full script of shifts, closed by the implicit write.
      for (int i = 0; i < SCR_DEPTH; i++) begin
         write_script(i, 1);
         exp_cmd_q.push_back(1);
      end
      exp_cmd_q.push_back(0);
      p0 = pulse_cnt;
      pulse_start();
      ctrl_run(-1);
      check_val("run3_pulses", 32'(pulse_cnt - p0), 32'(SCR_DEPTH + 1));
      check_status("run3", 16'h07E0, 64, 1, 0);
      check_results(1'b0);

      // Run 4: reset in the middle of the write-back, then a clean rerun.
      for (int i = 0; i <= SCR_DEPTH; i++) begin
         exp_cmd_q.push_back(i == SCR_DEPTH ? 0 : 1);
      end
      pulse_start();
      ctrl_run(10);
      #1;
      check_val("abort_checksum", {16'd0, checksum}, 32'd45);
      check_val("abort_wr_count", {25'd0, wr_count}, 32'd10);
      reset = 1'b1;
      #1;
      check_val("rst_cmd", {28'd0, cmd}, 32'hF);
      check_val("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
      check_val("rst_checksum", {16'd0, checksum}, 32'd0);
      check_val("rst_wr_count", {25'd0, wr_count}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      busy  = 1'b0;
      for (int i = 0; i <= SCR_DEPTH; i++) begin
         exp_cmd_q.push_back(i == SCR_DEPTH ? 0 : 1);
      end
      pulse_start();
      ctrl_run(-1);
      check_status("rerun", 16'h07E0, 64, 1, 0);

      // Run 5: controller never ready, expect timeout.
      busy = 1'b1;
      p0   = pulse_cnt;
      pulse_start();
      n = 0;
      while (error !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check_val("timeout_cycles", 32'(n), 32'(TIMEOUT));
      check_val("timeout_pulses", 32'(pulse_cnt - p0), 32'd0);
      check_status("timeout", 0, 0, 0, 1);
      busy = 1'b0;
      repeat (3) @(negedge clk);
      check_val("err_sticky", {31'd0, error}, 32'd1);

      check_val("cmd_sb_drain", 32'(exp_cmd_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lcd_host_seq.md
Name: lcd_host_seq

Overview:
- Host-side counterpart of the LCD controller: the other end of its cmd/busy/done handshake and of its IROM/IRAM ports.
- Holds a 64-byte source image and serves it combinationally as the IROM.
- Replays a stored command script to the controller, then captures the 64-byte IRAM write-back and reports a checksum.
- Used as the synthesizable system-level driver/scoreboard around the controller.

Parameters:
SCR_DEPTH, 16, number of script entries (power of two)
SCR_AW, 4, script address width, log2(SCR_DEPTH)
TIMEOUT, 255, max cycles spent in WAIT_RDY or WAIT_DONE before error

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a run
img_we  in  1  image load strobe
img_addr  in  6  image load address
img_data  in  8  image load data
scr_we  in  1  script load strobe
scr_addr  in  SCR_AW  script load address
scr_data  in  4  script entry (command code)
cmd  out  4  command to controller
cmd_valid  out  1  command strobe
busy  in  1  controller busy
done  in  1  controller done
IROM_rd  in  1  image read enable
IROM_A  in  6  image read address
IROM_Q  out  8  image read data
IRAM_valid  in  1  write-back strobe
IRAM_A  in  6  write-back address
IRAM_D  in  8  write-back data
res_addr  in  6  result readout address
res_data  out  8  result readout data
checksum  out  16  sum of captured IRAM_D, mod 2^16
wr_count  out  7  number of IRAM writes captured this run
finished  out  1  run completed normally (sticky)
error  out  1  timeout occurred (sticky)

Behaviour:
- Reset values:
  - state=IDLE; cmd=4'hF; cmd_valid=0.
  - checksum=0; wr_count=0; finished=0; error=0; ptr=0; timer=0.
  - Image, script and result memories are not reset; their contents persist across reset.
- Memory writes:
  - img_we / scr_we write on posedge clk in any state.
- IROM_Q:
  - Combinational: img[IROM_A] when IROM_rd=1, else 8'h00. Zero latency; the controller samples it in the same cycle.
- Result capture:
  - On posedge clk with IRAM_valid=1 in WAIT_DONE, writes the result memory: res[IRAM_A] <= IRAM_D.
  - Same edge: checksum += IRAM_D (zero-extended); wr_count += 1, saturating at 64.
  - IRAM_valid outside WAIT_DONE is ignored.
- res_data = res[res_addr], combinational.
- Idle command encoding:
  - Whenever cmd_valid=0, cmd=4'hF; 15 is a no-op code for the controller.
- cmd_valid width:
  - cmd_valid is high for exactly one cycle per command.
  - Consecutive commands are separated by at least one idle cycle.
- FSM:
  - IDLE/FINISH/ERR + start:
    - -> WAIT_RDY.
    - Clears ptr, timer, checksum, wr_count, finished, error.
  - WAIT_RDY:
    - If busy=0 at the edge: cmd <= (ptr==SCR_DEPTH) ? 0 : script[ptr]; cmd_valid <= 1; ptr++; timer <= 0; -> ISSUE.
    - Else timer++; at timer==TIMEOUT -> ERR.
    - ptr is SCR_AW+1 bits wide, so a script with no 0 entry gets an automatic 0 (write) after SCR_DEPTH commands.
  - ISSUE (one cycle):
    - cmd_valid <= 0; cmd <= 4'hF.
    - If the issued code was 0 -> WAIT_DONE, else -> WAIT_RDY.
  - WAIT_DONE:
    - Captures writes as above; timer++ each cycle.
    - done=1 -> FINISH, finished <= 1.
    - timer==TIMEOUT before done -> ERR.
  - FINISH: finished held until the next start.
  - ERR: error held, cmd_valid=0, until start or reset.
- Precedence and ignored inputs:
  - start is ignored in WAIT_RDY, ISSUE and WAIT_DONE.
  - If done and timeout occur on the same edge, done wins.
- Throughput: one command per 2 cycles while busy=0.
- Reset mid-run returns to IDLE immediately; outputs take reset values.

Test Plan:
- img[i]=i, script[0]=0, start -> 64 IROM reads answered (IROM_Q==IROM_A), one cmd 0 pulse, 64 writes; checksum=16'h07E0, wr_count=64, finished=1.
- img[i]=i, script={5,0}, start -> MAX applied at window x=4,y=4 (addresses 27,28,35,36) sets res[27]=res[28]=res[35]=res[36]=36; checksum=2034 (0x07F2).
- img[i]=i, all 16 script entries=1 -> 16 cmd_valid pulses with cmd=1, then an automatic cmd=0; res identical to img; checksum=0x07E0.
- busy tied 1, start -> cmd_valid never asserts; error=1 exactly TIMEOUT cycles after entering WAIT_RDY; finished=0.
- Assert reset during WAIT_DONE -> cmd=F, cmd_valid=0, checksum=0, state IDLE; a new start reruns and re-reaches checksum=0x07E0.
- Every cmd_valid pulse is exactly 1 cycle wide, with cmd=4'hF in all cycles where cmd_valid=0 (checked by assertion across all scenarios).
